// File: rtl/ysyx_23060201_mem_arb.sv
// ysyx_23060201_mem_arb: round-robin IFU/LSU arbiter sequencing one transaction at a time onto the shared memory port
module ysyx_23060201_mem_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [7:0] IFU_RMASK = 8'h0F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
  output logic                  ifu_rsp_valid,
  input  logic                  ifu_rsp_ready,
  output logic [DATA_WIDTH-1:0] ifu_rsp_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_req_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
  input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
  input  logic [7:0]            lsu_req_mask,
  output logic                  lsu_rsp_valid,
  input  logic                  lsu_rsp_ready,
  output logic [DATA_WIDTH-1:0] lsu_rsp_rdata,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [7:0]            mem_rmask,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_wmask
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;
  state_e state_q, state_d;
  // owner/last_grant: 1 = LSU, 0 = IFU
  logic owner_q, owner_d, last_q, last_d, wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0] mask_q, mask_d;
  logic idle, acc, resp, gnt_lsu;
  assign idle = ~rst & (state_q == IDLE);
  assign acc = ~rst & (state_q == ACCESS);
  assign resp = ~rst & (state_q == RESP);
  assign gnt_lsu = lsu_req_valid & (~ifu_req_valid | ~last_q);
  assign ifu_req_ready = idle & ifu_req_valid & ~gnt_lsu;
  assign lsu_req_ready = idle & gnt_lsu;
  assign ifu_rsp_valid = resp & ~owner_q;
  assign lsu_rsp_valid = resp & owner_q;
  assign ifu_rsp_rdata = ifu_rsp_valid ? rdata_q : '0;
  assign lsu_rsp_rdata = lsu_rsp_valid ? rdata_q : '0;
  assign mem_ren = acc & ~wen_q;
  assign mem_wen = acc & wen_q;
  assign mem_raddr = mem_ren ? addr_q : '0;
  assign mem_rmask = mem_ren ? mask_q : '0;
  assign mem_waddr = mem_wen ? addr_q : '0;
  assign mem_wdata = mem_wen ? wdata_q : '0;
  assign mem_wmask = mem_wen ? mask_q : '0;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    wen_d = wen_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    mask_d = mask_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (ifu_req_ready | lsu_req_ready) begin
        state_d = ACCESS;
        owner_d = gnt_lsu;
        last_d = gnt_lsu;
        wen_d = gnt_lsu & lsu_req_wen;
        addr_d = gnt_lsu ? lsu_req_addr : ifu_req_addr;
        wdata_d = lsu_req_wdata;
        mask_d = gnt_lsu ? lsu_req_mask : IFU_RMASK;
      end
      ACCESS: begin
        state_d = wen_q ? RESP : WAIT;
        rdata_d = wen_q ? '0 : rdata_q;
      end
      WAIT: begin
        state_d = RESP;
        rdata_d = mem_rdata;
      end
      RESP: state_d = (owner_q ? lsu_rsp_ready : ifu_rsp_ready) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      wen_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      mask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      wen_q <= wen_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      mask_q <= mask_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_ysyx_23060201_mem_arb.sv
// tb_ysyx_23060201_mem_arb: directed bench with a registered-read memory model and per-cycle port invariants
module tb_ysyx_23060201_mem_arb;
  logic clk = 1'b0, rst = 1'b1;
  logic ifu_req_valid = 1'b0, ifu_rsp_ready = 1'b0;
  logic [31:0] ifu_req_addr = '0;
  logic lsu_req_valid = 1'b0, lsu_req_wen = 1'b0, lsu_rsp_ready = 1'b0;
  logic [31:0] lsu_req_addr = '0, lsu_req_wdata = '0;
  logic [7:0] lsu_req_mask = '0;
  logic ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid;
  logic [31:0] ifu_rsp_rdata, lsu_rsp_rdata;
  logic mem_ren, mem_wen;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [7:0] mem_rmask, mem_wmask;
  logic [31:0] rd_val = '0;
  int checks = 0, errs = 0, ren_cnt = 0, wr_cnt = 0, ren_s = 0, wr_s = 0;
  ysyx_23060201_mem_arb dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_mask(lsu_req_mask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rmask(mem_rmask), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask
  always @(posedge clk) begin
    if (mem_ren) begin
      mem_rdata <= rd_val;
      ren_cnt++;
    end
    if (mem_wen) wr_cnt++;
  end
  always @(posedge clk) begin
    #3;
    chk("mon_excl", 96'(mem_ren & mem_wen), 96'(0));
    if (!mem_ren) chk("mon_rport_zero", 96'({mem_raddr, mem_rmask}), 96'(0));
    if (!mem_wen) chk("mon_wport_zero", 96'({mem_waddr, mem_wdata, mem_wmask}), 96'(0));
  end
  initial begin
    @(negedge clk);
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1;
    chk("rst_ifu_ready", 96'(ifu_req_ready), 96'(0));
    chk("rst_lsu_ready", 96'(lsu_req_ready), 96'(0));
    chk("rst_rsp_valid", 96'({ifu_rsp_valid, lsu_rsp_valid}), 96'(0));
    cyc;
    cyc;
    rst = 1'b0;
    lsu_req_valid = 1'b0;
    ifu_req_addr = 32'h8000_0000;
    rd_val = 32'h0000_0413;
    #1;
    chk("f_ifu_ready", 96'(ifu_req_ready), 96'(1));
    chk("f_lsu_ready", 96'(lsu_req_ready), 96'(0));
    cyc;
    ifu_req_valid = 1'b0;
    #1;
    chk("f_ren", 96'(mem_ren), 96'(1));
    chk("f_raddr", 96'(mem_raddr), 96'(32'h8000_0000));
    chk("f_rmask", 96'(mem_rmask), 96'(8'h0F));
    chk("f_wen", 96'(mem_wen), 96'(0));
    chk("f_busy_ready", 96'(ifu_req_ready), 96'(0));
    cyc;
    #1;
    chk("f_wait_ren", 96'(mem_ren), 96'(0));
    chk("f_wait_valid", 96'(ifu_rsp_valid), 96'(0));
    cyc;
    #1;
    chk("f_rsp_valid", 96'(ifu_rsp_valid), 96'(1));
    chk("f_rsp_rdata", 96'(ifu_rsp_rdata), 96'(32'h0000_0413));
    chk("f_lsu_rsp", 96'(lsu_rsp_valid), 96'(0));
    ifu_rsp_ready = 1'b1;
    cyc;
    ifu_rsp_ready = 1'b0;
    #1;
    chk("f_done", 96'(ifu_rsp_valid), 96'(0));
    ren_s = ren_cnt;
    wr_s = wr_cnt;
    lsu_req_valid = 1'b1;
    lsu_req_wen = 1'b1;
    lsu_req_addr = 32'h8000_0100;
    lsu_req_wdata = 32'hDEAD_BEEF;
    lsu_req_mask = 8'h0F;
    #1;
    chk("s_lsu_ready", 96'(lsu_req_ready), 96'(1));
    cyc;
    lsu_req_valid = 1'b0;
    #1;
    chk("s_wen", 96'(mem_wen), 96'(1));
    chk("s_wport", 96'({mem_waddr, mem_wdata, mem_wmask}), 96'({32'h8000_0100, 32'hDEAD_BEEF, 8'h0F}));
    chk("s_ren", 96'(mem_ren), 96'(0));
    cyc;
    #1;
    chk("s_rsp_valid", 96'(lsu_rsp_valid), 96'(1));
    chk("s_rsp_rdata", 96'(lsu_rsp_rdata), 96'(0));
    chk("s_wcount", 96'(wr_cnt - wr_s), 96'(1));
    lsu_rsp_ready = 1'b1;
    cyc;
    #1;
    chk("s_done", 96'(lsu_rsp_valid), 96'(0));
    chk("s_no_read", 96'(ren_cnt - ren_s), 96'(0));
    rst = 1'b1;
    lsu_req_wen = 1'b0;
    cyc;
    rst = 1'b0;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    ifu_rsp_ready = 1'b1;
    lsu_rsp_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("alt_ifu_ready", 96'(ifu_req_ready), 96'(k % 8 == 0));
      chk("alt_lsu_ready", 96'(lsu_req_ready), 96'(k % 8 == 4));
      cyc;
    end
    ifu_req_valid = 1'b0;
    ifu_rsp_ready = 1'b0;
    lsu_rsp_ready = 1'b0;
    lsu_req_addr = 32'h8000_0200;
    rd_val = 32'h1234_5678;
    #1;
    chk("h_lsu_ready", 96'(lsu_req_ready), 96'(1));
    cyc;
    lsu_req_valid = 1'b0;
    ifu_req_valid = 1'b1;
    cyc;
    cyc;
    ren_s = ren_cnt;
    wr_s = wr_cnt;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("h_rsp_valid", 96'(lsu_rsp_valid), 96'(1));
      chk("h_rsp_rdata", 96'(lsu_rsp_rdata), 96'(32'h1234_5678));
      chk("h_ifu_ready", 96'(ifu_req_ready), 96'(0));
      chk("h_ifu_rsp", 96'(ifu_rsp_valid), 96'(0));
      cyc;
    end
    chk("h_no_strobes", 96'({ren_cnt - ren_s, wr_cnt - wr_s}), 96'(0));
    lsu_rsp_ready = 1'b1;
    cyc;
    lsu_rsp_ready = 1'b0;
    #1;
    chk("h_next_accept", 96'(ifu_req_ready), 96'(1));
    ifu_req_valid = 1'b0;
    cyc;
    wr_s = wr_cnt;
    lsu_req_valid = 1'b1;
    lsu_req_wen = 1'b1;
    lsu_req_addr = 32'h8000_0300;
    lsu_req_wdata = 32'hCAFE_F00D;
    lsu_req_mask = 8'h03;
    #1;
    chk("r_lsu_ready", 96'(lsu_req_ready), 96'(1));
    cyc;
    lsu_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("r_wen_gated", 96'(mem_wen), 96'(0));
    chk("r_rsp_valid", 96'(lsu_rsp_valid), 96'(0));
    cyc;
    rst = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_req_addr = 32'h8000_0004;
    rd_val = 32'h0010_0093;
    #1;
    chk("r_no_rsp", 96'(lsu_rsp_valid), 96'(0));
    chk("r_ifu_ready", 96'(ifu_req_ready), 96'(1));
    cyc;
    ifu_req_valid = 1'b0;
    ifu_rsp_ready = 1'b1;
    #1;
    chk("r_ren", 96'({mem_ren, mem_raddr}), 96'({1'b1, 32'h8000_0004}));
    chk("r_no_write", 96'(wr_cnt - wr_s), 96'(0));
    cyc;
    cyc;
    #1;
    chk("r_ifu_rsp", 96'({ifu_rsp_valid, ifu_rsp_rdata}), 96'({1'b1, 32'h0010_0093}));
    cyc;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_23060201_mem_arb.md
# ysyx_23060201_mem_arb

Two-master memory arbiter and sequencer placed between the instruction fetch unit (IFU) and the load/store unit (LSU) and the single shared physical-memory port of `ysyx_23060201_MEM`. The arbiter accepts requests over valid/ready handshakes and grants round-robin. It issues exactly one one-cycle read or write strobe per transaction and captures the registered read data. It then holds the response until the owning master accepts it. Only one transaction is in flight at a time.

## Interface
- `ADDR_WIDTH`, 32, address width for both masters and the memory port
- `DATA_WIDTH`, 32, data width
- `IFU_RMASK`, 8'h0F, read mask driven for every IFU fetch

- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  synchronous reset, active-high
- `ifu_req_valid`  in  1  IFU fetch request
- `ifu_req_ready`  out  1  IFU request accepted this cycle
- `ifu_req_addr`  in  ADDR_WIDTH  fetch address
- `ifu_rsp_valid`  out  1  IFU response available
- `ifu_rsp_ready`  in  1  IFU consumes response
- `ifu_rsp_rdata`  out  DATA_WIDTH  fetched word
- `lsu_req_valid`  in  1  LSU request
- `lsu_req_ready`  out  1  LSU request accepted this cycle
- `lsu_req_wen`  in  1  1 = store, 0 = load
- `lsu_req_addr`  in  ADDR_WIDTH  access address
- `lsu_req_wdata`  in  DATA_WIDTH  store data
- `lsu_req_mask`  in  8  byte mask; used as the read mask or the write mask
- `lsu_rsp_valid`  out  1  LSU response available (load data, or store completion)
- `lsu_rsp_ready`  in  1  LSU consumes response
- `lsu_rsp_rdata`  out  DATA_WIDTH  load data; 0 for stores
- `mem_ren`, `mem_raddr`, `mem_rmask`  out  1 / ADDR_WIDTH / 8  memory read port
- `mem_rdata`  in  DATA_WIDTH  memory read data, registered by the memory, valid the cycle after `mem_ren`
- `mem_wen`, `mem_waddr`, `mem_wdata`, `mem_wmask`  out  1 / ADDR_WIDTH / DATA_WIDTH / 8  memory write port; the memory commits the write on the negedge of the strobe cycle

## Operation
- State machine states: IDLE, ACCESS, WAIT, RESP. The `owner` register (IFU/LSU) and the `last_grant` register are held alongside the state.
- IDLE:
  - Exactly one of `*_req_ready` is asserted combinationally when any valid is high; the other ready is 0.
  - Grant rules: if only one master is valid, grant it. If both are valid, grant the master that is not `last_grant`.
  - On a handshake (valid & ready):
    - latch addr, wen, wdata, mask and owner;
    - update `last_grant`;
    - go to ACCESS.
  - IFU requests latch wen=0 and mask=`IFU_RMASK`.
- ACCESS:
  - Drive `mem_ren`=1 for a read, or `mem_wen`=1 for a write, for exactly this cycle, using the latched fields.
  - Next state: read → WAIT; write → RESP, with the response data register set to 0.
- WAIT: capture `mem_rdata` into the response data register, then go to RESP.
- RESP:
  - Assert the owner's `*_rsp_valid` with the held data; the non-owner's rsp_valid stays 0.
  - On owner's `*_rsp_ready`, go to IDLE. Otherwise hold state; data and valid remain stable.
- Memory-port outputs are 0 whenever their strobe is 0. Both `*_req_ready` are 0 outside IDLE.
- `mem_ren` and `mem_wen` are never high together.
- No alignment checking is done; addresses pass through unmodified.

## Timing
- Reset:
  - state=IDLE, `last_grant`=LSU (so IFU wins the first tie), response data register=0.
  - All outputs read 0 while `rst` is high. In particular `mem_ren`/`mem_wen` are gated by `~rst`, so no access is issued in a reset cycle.
- Reset mid-transaction (any state): the transaction is dropped with no response and no memory strobe. The arbiter returns to IDLE at the next edge.
- Read latency:
  - handshake in cycle T;
  - `mem_ren` in T+1;
  - data captured at the end of T+2;
  - `rsp_valid` from T+3.
- Write latency: handshake in T, `mem_wen` in T+1, `rsp_valid` from T+2.
- Next-request acceptance: the earliest next request is accepted in the cycle after the `rsp_ready` handshake.
- Back-to-back throughput with ready always high: 4 cycles per read, 3 cycles per write.
- Request stability: a master may change or drop a request while not ready; nothing is latched without a handshake.

## Test plan
- Reset, then IFU fetch of 0x8000_0000 with memory returning 0x0000_0413 → `mem_ren` with `mem_rmask`=0x0F in T+1; `ifu_rsp_valid` in T+3 with `ifu_rsp_rdata`=0x0000_0413.
- LSU store to addr 0x8000_0100, wdata 0xDEADBEEF, mask 0x0F → one `mem_wen` cycle with those values; `lsu_rsp_valid` in T+2 with `lsu_rsp_rdata`=0; `mem_ren` stays 0 throughout.
- IFU and LSU both valid continuously from reset → grants alternate IFU, LSU, IFU, LSU; each `*_req_ready` pulse is a single cycle.
- Hold `lsu_rsp_ready`=0 for 5 cycles after a load returning 0x1234_5678 → `lsu_rsp_valid` and data stay stable; `ifu_req_ready` stays 0; no memory strobes occur.
- Assert `rst` in the ACCESS cycle of a store → `mem_wen`=0 that cycle; no response; state is IDLE afterward and the next IFU request is granted.
- Check every cycle: `mem_ren`&`mem_wen` never both 1; all `mem_*` address/data/mask outputs are 0 whenever their strobe is low.
